// File: rtl/riscv_decode_stage_if.sv
// riscv_decode_stage_if: D-stage inputs, writeback port and registered E-stage
// bundle of the decode stage, grouped so the core and the bench can hand the
// whole bus around as one port.
//   slave  : used by riscv_decode_stage (takes D/W/control inputs, drives E outputs)
//   master : used by whoever drives the decode stage (IF/ID side, hazard unit, bench)
// XLEN must match the XLEN of the decode stage it is connected to.
interface riscv_decode_stage_if #(
  parameter int XLEN = 32
);
  // D stage and pipeline control
  logic            i_valid_d;
  logic [XLEN-1:0] i_instr_d;
  logic [XLEN-1:0] i_pc_d;
  logic            i_stall;
  logic            i_flush;
  // writeback port
  logic            i_reg_write_w;
  logic [4:0]      i_rd_w;
  logic [XLEN-1:0] i_result_w;
  // hazard output
  logic            o_stall_fd;
  // registered E bundle
  logic            o_valid_e;
  logic [XLEN-1:0] o_pc_e, o_rd1_e, o_rd2_e, o_extimm_e;
  logic [4:0]      o_rs1_e, o_rs2_e, o_rd_e;
  logic [1:0]      o_result_src_e;
  logic            o_alu_src_a_e, o_alu_src_b_e, o_reg_write_e, o_mem_write_e;
  logic [3:0]      o_mem_byte_sel_e, o_alu_control_e;
  logic            o_jalr_e, o_jump_e, o_branch_e, o_zero_condition_e, o_unsigned_e;

  modport slave (
    input  i_valid_d, i_instr_d, i_pc_d, i_stall, i_flush,
           i_reg_write_w, i_rd_w, i_result_w,
    output o_stall_fd, o_valid_e, o_pc_e, o_rd1_e, o_rd2_e, o_extimm_e,
           o_rs1_e, o_rs2_e, o_rd_e, o_result_src_e, o_alu_src_a_e, o_alu_src_b_e,
           o_reg_write_e, o_mem_write_e, o_mem_byte_sel_e, o_alu_control_e,
           o_jalr_e, o_jump_e, o_branch_e, o_zero_condition_e, o_unsigned_e
  );

  modport master (
    output i_valid_d, i_instr_d, i_pc_d, i_stall, i_flush,
           i_reg_write_w, i_rd_w, i_result_w,
    input  o_stall_fd, o_valid_e, o_pc_e, o_rd1_e, o_rd2_e, o_extimm_e,
           o_rs1_e, o_rs2_e, o_rd_e, o_result_src_e, o_alu_src_a_e, o_alu_src_b_e,
           o_reg_write_e, o_mem_write_e, o_mem_byte_sel_e, o_alu_control_e,
           o_jalr_e, o_jump_e, o_branch_e, o_zero_condition_e, o_unsigned_e
  );
endinterface

// File: rtl/riscv_decode_stage.sv
// riscv_decode_stage: RV32I/RV32E decode with register file, immediate
// extender, load-use hazard detection and the ID/EX pipeline register.
//   i_clk, i_rstn : clock (rising edge) and asynchronous active-low reset
//   bus (slave)   : D-stage instruction/pc/valid, i_stall/i_flush, writeback
//                   port in; o_stall_fd and the registered E bundle out
// Parameters: XLEN (datapath width), NREG (32 = RV32I, 16 = RV32E).
// Build option: define RISCV_DECODE_WTBYPASS_EN to make same-cycle writeback
// visible to the D-stage register read (write-through).
//
// Control encoding:
//   result_src   00 ALU, 01 memory, 10 pc+4 (jal/jalr), 11 extended immediate (lui)
//   alu_src_a    1 = pc (auipc, jal), alu_src_b 1 = immediate
//   alu_control  0 add 1 sub 2 sll 3 slt 4 sltu 5 xor 6 srl 7 sra 8 or 9 and
//   mem_byte_sel 0001 byte, 0011 half, 1111 word
//   branch taken when (alu result == 0) == zero_condition
module riscv_decode_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  riscv_decode_stage_if.slave  bus
);
  localparam int AW = $clog2(NREG);

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                         ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_OR = 4'd8, ALU_AND = 4'd9;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_src_t;

  typedef struct packed {
    logic [1:0] result_src;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       reg_write;
    logic       mem_write;
    logic [3:0] byte_sel;
    logic [3:0] alu_control;
    logic       jalr;
    logic       jump;
    logic       branch;
    logic       zero_cond;
    logic       is_unsigned;
  } ctl_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    ctl_t            ctl;
  } e_t;

  // ---------------- field extraction ----------------
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic        f7b5;
  logic [4:0]  rs1, rs2, rd;

  assign instr  = 32'(bus.i_instr_d);
  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7b5   = instr[30];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];

  function automatic logic [3:0] alu_dec(input logic [2:0] fn3, input logic b5, input logic is_r);
    case (fn3)
      3'b000:  return (is_r && b5) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return b5 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [3:0] size_sel(input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // ---------------- control unit ----------------
  ctl_t     ctl;
  imm_src_t imm_src;

  always_comb begin
    ctl     = '0;
    imm_src = IMM_I;  // R-type has no immediate; the I extractor stays selected
    case (opcode)
      7'b0000011: begin  // loads
        ctl.reg_write   = 1'b1;
        ctl.alu_src_b   = 1'b1;
        ctl.result_src  = 2'b01;
        ctl.byte_sel    = size_sel(f3[1:0]);
        ctl.is_unsigned = f3[2];
      end
      7'b0100011: begin  // stores
        imm_src       = IMM_S;
        ctl.mem_write = 1'b1;
        ctl.alu_src_b = 1'b1;
        ctl.byte_sel  = size_sel(f3[1:0]);
      end
      7'b0110011: begin  // register-register ALU
        ctl.reg_write   = 1'b1;
        ctl.alu_control = alu_dec(f3, f7b5, 1'b1);
        ctl.is_unsigned = (f3 == 3'b011);
      end
      7'b0010011: begin  // register-immediate ALU
        ctl.reg_write   = 1'b1;
        ctl.alu_src_b   = 1'b1;
        ctl.alu_control = alu_dec(f3, f7b5, 1'b0);
        ctl.is_unsigned = (f3 == 3'b011);
      end
      7'b1100011: begin  // branches: compare via sub/slt/sltu, polarity in zero_cond
        imm_src         = IMM_B;
        ctl.branch      = 1'b1;
        ctl.alu_control = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        ctl.zero_cond   = f3[2] ? f3[0] : ~f3[0];
        ctl.is_unsigned = f3[2] & f3[1];
      end
      7'b1101111: begin  // jal
        imm_src        = IMM_J;
        ctl.jump       = 1'b1;
        ctl.reg_write  = 1'b1;
        ctl.result_src = 2'b10;
        ctl.alu_src_a  = 1'b1;
        ctl.alu_src_b  = 1'b1;
      end
      7'b1100111: begin  // jalr
        ctl.jump       = 1'b1;
        ctl.jalr       = 1'b1;
        ctl.reg_write  = 1'b1;
        ctl.result_src = 2'b10;
        ctl.alu_src_b  = 1'b1;
      end
      7'b0110111: begin  // lui
        imm_src        = IMM_U;
        ctl.reg_write  = 1'b1;
        ctl.result_src = 2'b11;
      end
      7'b0010111: begin  // auipc
        imm_src       = IMM_U;
        ctl.reg_write = 1'b1;
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------- immediate extender ----------------
  logic [31:0] imm32;

  always_comb begin
    case (imm_src)
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = {{20{instr[31]}}, instr[31:20]};
    endcase
  end

  // ---------------- register file ----------------
  logic [XLEN-1:0] rf [NREG];
  logic            wr_en;
  logic [XLEN-1:0] rd1, rd2;

  // x0 and indices beyond NREG (RV32E) are not storage
  assign wr_en = bus.i_reg_write_w && (bus.i_rd_w != 5'd0) && (int'(bus.i_rd_w) < NREG);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wr_en) begin
      rf[bus.i_rd_w[AW-1:0]] <= bus.i_result_w;
    end
  end

  always_comb begin
    rd1 = (rs1 != 5'd0 && int'(rs1) < NREG) ? rf[rs1[AW-1:0]] : '0;
    rd2 = (rs2 != 5'd0 && int'(rs2) < NREG) ? rf[rs2[AW-1:0]] : '0;
`ifdef RISCV_DECODE_WTBYPASS_EN
    // wr_en already excludes x0 and out-of-range indices
    if (wr_en && bus.i_rd_w == rs1) rd1 = bus.i_result_w;
    if (wr_en && bus.i_rd_w == rs2) rd2 = bus.i_result_w;
`endif
  end

  // ---------------- hazard detection ----------------
  e_t   e_q;
  logic load_use;

  // rs2 compared for every format: a false stall costs one cycle, a missed one corrupts data
  assign load_use = e_q.valid && (e_q.ctl.result_src == 2'b01) && (e_q.rd != 5'd0) &&
                    bus.i_valid_d && ((e_q.rd == rs1) || (e_q.rd == rs2));

  assign bus.o_stall_fd = bus.i_stall | load_use;

  // ---------------- ID/EX register ----------------
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      e_q <= '0;
    end else if (bus.i_flush) begin
      e_q <= '0;
    end else if (bus.i_stall) begin
      e_q <= e_q;
    end else if (load_use) begin
      e_q <= '0;  // bubble; the D instruction is held upstream by o_stall_fd
    end else begin
      e_q.valid <= bus.i_valid_d;
      e_q.pc    <= bus.i_pc_d;
      e_q.rd1   <= rd1;
      e_q.rd2   <= rd2;
      e_q.imm   <= XLEN'(imm32);
      e_q.rs1   <= rs1;
      e_q.rs2   <= rs2;
      e_q.rd    <= rd;
      e_q.ctl   <= bus.i_valid_d ? ctl : '0;
    end
  end

  assign bus.o_valid_e          = e_q.valid;
  assign bus.o_pc_e             = e_q.pc;
  assign bus.o_rd1_e            = e_q.rd1;
  assign bus.o_rd2_e            = e_q.rd2;
  assign bus.o_extimm_e         = e_q.imm;
  assign bus.o_rs1_e            = e_q.rs1;
  assign bus.o_rs2_e            = e_q.rs2;
  assign bus.o_rd_e             = e_q.rd;
  assign bus.o_result_src_e     = e_q.ctl.result_src;
  assign bus.o_alu_src_a_e      = e_q.ctl.alu_src_a;
  assign bus.o_alu_src_b_e      = e_q.ctl.alu_src_b;
  assign bus.o_reg_write_e      = e_q.ctl.reg_write;
  assign bus.o_mem_write_e      = e_q.ctl.mem_write;
  assign bus.o_mem_byte_sel_e   = e_q.ctl.byte_sel;
  assign bus.o_alu_control_e    = e_q.ctl.alu_control;
  assign bus.o_jalr_e           = e_q.ctl.jalr;
  assign bus.o_jump_e           = e_q.ctl.jump;
  assign bus.o_branch_e         = e_q.ctl.branch;
  assign bus.o_zero_condition_e = e_q.ctl.zero_cond;
  assign bus.o_unsigned_e       = e_q.ctl.is_unsigned;
endmodule

// File: tb/tb_riscv_decode_stage.sv
// tb_riscv_decode_stage: table-driven decode vectors through a scoreboard queue,
// plus hand-written sequences for load-use, stall/flush, write-through, mid-stream
// reset and the RV32E (NREG=16) register file.
module tb_riscv_decode_stage;
  localparam int XLEN = 32;
`ifdef RISCV_DECODE_WTBYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  riscv_decode_stage_if #(.XLEN(XLEN)) bus();
  riscv_decode_stage_if #(.XLEN(XLEN)) b16();

  riscv_decode_stage #(.XLEN(XLEN), .NREG(32)) dut   (.i_clk(clk), .i_rstn(rstn), .bus(bus.slave));
  riscv_decode_stage #(.XLEN(XLEN), .NREG(16)) dut16 (.i_clk(clk), .i_rstn(rstn), .bus(b16.slave));

  typedef struct {
    logic        valid;
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [1:0]  rsrc;
    logic        asb, rw, mw, br, jp;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    exp_t        exp;
  } vec_t;

  int   pass = 0;
  int   total = 0;
  exp_t q[$];

  function automatic exp_t e(input logic v, input logic [31:0] pc, rd1, rd2, imm,
                             input logic [4:0] rs1, rs2, rd, input logic [1:0] rsrc,
                             input logic asb, rw, mw, br, jp);
    exp_t r;
    r.valid = v; r.pc = pc; r.rd1 = rd1; r.rd2 = rd2; r.imm = imm;
    r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.rsrc = rsrc;
    r.asb = asb; r.rw = rw; r.mw = mw; r.br = br; r.jp = jp;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_e(input string tag, input exp_t x);
    chk({tag, ".valid"},   32'(bus.o_valid_e),      32'(x.valid));
    chk({tag, ".pc"},      bus.o_pc_e,              x.pc);
    chk({tag, ".rd1"},     bus.o_rd1_e,             x.rd1);
    chk({tag, ".rd2"},     bus.o_rd2_e,             x.rd2);
    chk({tag, ".imm"},     bus.o_extimm_e,          x.imm);
    chk({tag, ".rs1"},     32'(bus.o_rs1_e),        32'(x.rs1));
    chk({tag, ".rs2"},     32'(bus.o_rs2_e),        32'(x.rs2));
    chk({tag, ".rd"},      32'(bus.o_rd_e),         32'(x.rd));
    chk({tag, ".rsrc"},    32'(bus.o_result_src_e), 32'(x.rsrc));
    chk({tag, ".alusrcb"}, 32'(bus.o_alu_src_b_e),  32'(x.asb));
    chk({tag, ".regwr"},   32'(bus.o_reg_write_e),  32'(x.rw));
    chk({tag, ".memwr"},   32'(bus.o_mem_write_e),  32'(x.mw));
    chk({tag, ".branch"},  32'(bus.o_branch_e),     32'(x.br));
    chk({tag, ".jump"},    32'(bus.o_jump_e),       32'(x.jp));
  endtask

  task automatic pop_check(input string tag);
    if (q.size() == 0) begin
      total++;
      $display("FAIL %s: scoreboard empty when E output was due", tag);
    end else begin
      check_e(tag, q.pop_front());
    end
  endtask

  task automatic drive_d(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    bus.i_valid_d = v; bus.i_instr_d = ins; bus.i_pc_d = pc;
  endtask

  task automatic wr(input logic en, input logic [4:0] r, input logic [31:0] val);
    bus.i_reg_write_w = en; bus.i_rd_w = r; bus.i_result_w = val;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] I_ADDI  = 32'h00500093;  // addi x1,x0,5
  localparam logic [31:0] I_ADD   = 32'h001101B3;  // add  x3,x2,x1
  localparam logic [31:0] I_SW    = 32'h0020A423;  // sw   x2,8(x1)
  localparam logic [31:0] I_BEQ   = 32'hFE208EE3;  // beq  x1,x2,-4
  localparam logic [31:0] I_LUI   = 32'h123453B7;  // lui  x7,0x12345
  localparam logic [31:0] I_JAL   = 32'h010000EF;  // jal  x1,16
  localparam logic [31:0] I_LW    = 32'h0000A103;  // lw   x2,0(x1)
  localparam logic [31:0] I_ADDI6 = 32'h00028313;  // addi x6,x5,0

  vec_t tbl[7];
  exp_t bubble, add_e;

  initial begin
    bubble = e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[0] = '{I_ADDI, 32'h100, e(1, 32'h100, 0,     32'h55, 5,            0, 5,  1,  0, 1, 1, 0, 0, 0)};
    tbl[1] = '{I_ADD,  32'h104, e(1, 32'h104, 32'h22, 32'h11, 1,           2, 1,  3,  0, 0, 1, 0, 0, 0)};
    tbl[2] = '{I_SW,   32'h108, e(1, 32'h108, 32'h11, 32'h22, 8,           1, 2,  8,  0, 1, 0, 1, 0, 0)};
    tbl[3] = '{I_BEQ,  32'h10C, e(1, 32'h10C, 32'h11, 32'h22, 32'hFFFFFFFC, 1, 2, 29, 0, 0, 0, 0, 1, 0)};
    tbl[4] = '{I_LUI,  32'h110, e(1, 32'h110, 0,     0,      32'h12345000, 8, 3,  7,  3, 0, 1, 0, 0, 0)};
    tbl[5] = '{I_JAL,  32'h114, e(1, 32'h114, 0,     0,      16,           0, 16, 1,  2, 1, 1, 0, 0, 1)};
    tbl[6] = '{I_LW,   32'h118, e(1, 32'h118, 32'h11, 0,     0,            1, 0,  2,  1, 1, 1, 0, 0, 0)};
    add_e  = e(1, 32'h11C, 32'h22, 32'h11, 1, 2, 1, 3, 0, 0, 1, 0, 0, 0);

    drive_d(0, 0, 0); wr(0, 0, 0); bus.i_stall = 0; bus.i_flush = 0;
    b16.i_valid_d = 0; b16.i_instr_d = 0; b16.i_pc_d = 0; b16.i_stall = 0; b16.i_flush = 0;
    b16.i_reg_write_w = 0; b16.i_rd_w = 0; b16.i_result_w = 0;

    // reset state
    #12;
    check_e("reset", bubble);
    chk("reset.stall_fd", 32'(bus.o_stall_fd), 0);
    #6 rstn = 1'b1;

    // preload registers (D idle); RV32E side writes an out-of-range reg and x0
    step();
    wr(1, 5'd1, 32'h11); b16.i_reg_write_w = 1; b16.i_rd_w = 5'd20; b16.i_result_w = 32'h7;
    step();
    wr(1, 5'd2, 32'h22); b16.i_rd_w = 5'd3;  b16.i_result_w = 32'h33;
    step();
    wr(1, 5'd5, 32'h55); b16.i_rd_w = 5'd0;  b16.i_result_w = 32'h9;
    step();
    wr(0, 0, 0); b16.i_reg_write_w = 0;

    // NREG=16 reads: x20 is not storage, x3 is, x0 stays zero
    b16.i_valid_d = 1; b16.i_instr_d = 32'h000A0093;  // addi x1,x20,0
    step();
    chk("rv32e.x20", b16.o_rd1_e, 0);
    chk("rv32e.rs1", 32'(b16.o_rs1_e), 20);
    b16.i_instr_d = 32'h00018093;                    // addi x1,x3,0
    step();
    chk("rv32e.x3", b16.o_rd1_e, 32'h33);
    b16.i_instr_d = 32'h00000093;                    // addi x1,x0,0
    step();
    chk("rv32e.x0", b16.o_rd1_e, 0);
    b16.i_valid_d = 0;

    // table-driven decode vectors
    for (int i = 0; i < 7; i++) begin
      drive_d(1, tbl[i].instr, tbl[i].pc);
      #1;
      chk($sformatf("vec%0d.stall_fd", i), 32'(bus.o_stall_fd), 0);
      q.push_back(tbl[i].exp);
      step();
      pop_check($sformatf("vec%0d", i));
    end

    // load-use: LW x2 in E, ADD reading x2 in D -> one-cycle bubble
    drive_d(1, I_ADD, 32'h11C);
    #1;
    chk("lu.stall_fd", 32'(bus.o_stall_fd), 1);
    q.push_back(bubble);
    step();
    pop_check("lu.bubble");
    chk("lu.stall_released", 32'(bus.o_stall_fd), 0);
    q.push_back(add_e);
    step();
    pop_check("lu.add");

    // stall holds E, then flush overrides stall
    drive_d(1, I_BEQ, 32'h120);
    bus.i_stall = 1;
    #1;
    chk("hold.stall_fd", 32'(bus.o_stall_fd), 1);
    q.push_back(add_e);
    step();
    pop_check("hold");
    bus.i_flush = 1;
    q.push_back(bubble);
    step();
    pop_check("flush_stall");
    bus.i_stall = 0; bus.i_flush = 0;

    // flush and load-use together: flush wins, stall still raised
    drive_d(1, I_LW, 32'h200);
    q.push_back(e(1, 32'h200, 32'h11, 0, 0, 1, 0, 2, 1, 1, 1, 0, 0, 0));
    step();
    pop_check("fl.lw");
    drive_d(1, I_ADD, 32'h204);
    bus.i_flush = 1;
    #1;
    chk("fl.stall_fd", 32'(bus.o_stall_fd), 1);
    q.push_back(bubble);
    step();
    pop_check("fl.bubble");
    bus.i_flush = 0;

    // invalid D: data captured, control forced off
    drive_d(0, I_SW, 32'h300);
    q.push_back(e(0, 32'h300, 32'h11, 32'h22, 8, 1, 2, 8, 0, 0, 0, 0, 0, 0));
    step();
    pop_check("invalid_d");

    // same-cycle writeback of x5 while D reads x5
    drive_d(1, I_ADDI6, 32'h400);
    wr(1, 5'd5, 32'hDEADBEEF);
    q.push_back(e(1, 32'h400, BYP ? 32'hDEADBEEF : 32'h55, 0, 0, 5, 0, 6, 0, 1, 1, 0, 0, 0));
    step();
    pop_check("wt.same");
    wr(0, 0, 0);
    drive_d(1, I_ADDI6, 32'h404);
    q.push_back(e(1, 32'h404, 32'hDEADBEEF, 0, 0, 5, 0, 6, 0, 1, 1, 0, 0, 0));
    step();
    pop_check("wt.after");

    // mid-stream asynchronous reset
    drive_d(1, I_ADDI, 32'h500);
    q.push_back(tbl[0].exp);
    q[0].pc = 32'h500;
    q[0].rd2 = 32'hDEADBEEF;
    step();
    pop_check("pre_reset");
    #2 rstn = 1'b0;
    #1;
    check_e("async_reset", bubble);
    chk("async_reset.stall_fd", 32'(bus.o_stall_fd), 0);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    drive_d(1, I_ADD, 32'h600);
    q.push_back(e(1, 32'h600, 0, 0, 1, 2, 1, 3, 0, 0, 1, 0, 0, 0));
    step();
    pop_check("post_reset.x1x2");
    drive_d(1, I_ADDI6, 32'h604);
    q.push_back(e(1, 32'h604, 0, 0, 0, 5, 0, 6, 0, 1, 1, 0, 0, 0));
    step();
    pop_check("post_reset.x5");
    drive_d(0, 0, 0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
